// File: rtl/muxn_stream.sv
// muxn_stream: N-way stream selector with registered output, direct or round-robin channel choice.
// Optional MUXN_SELERR_EN adds a sticky sel_err flag for out-of-range direct selects.
module muxn_stream #(
    parameter  int WIDTH = 16,
    parameter  int N     = 3,
    localparam int SW    = $clog2(N)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             mode,
    input  logic [SW-1:0]    s,
    input  logic [N*WIDTH-1:0] d,
    input  logic [N-1:0]     in_valid,
    output logic [N-1:0]     in_ready,
    output logic [WIDTH-1:0] y,
    output logic             y_valid,
    output logic [SW-1:0]    y_sel,
    input  logic             out_ready
`ifdef MUXN_SELERR_EN
    ,
    output logic             sel_err
`endif
);
    logic [WIDTH-1:0] ch [N];
    logic [WIDTH-1:0] y_q, y_d;
    logic             y_valid_q, y_valid_d;
    logic [SW-1:0]    y_sel_q, y_sel_d;
    logic [SW-1:0]    rr_ptr_q, rr_ptr_d;
    logic             sel_err_q, sel_err_d;
    logic [SW:0]      rr_idx;
    logic [SW-1:0]    rr_c, c;
    logic             rr_found, s_ok, cand, free, accept;

    for (genvar k = 0; k < N; k++) begin : g_ch
        assign ch[k] = d[k*WIDTH +: WIDTH];
    end

    // Round-robin scan: first requesting channel starting at rr_ptr, wrapping modulo N.
    always_comb begin
        rr_found = 1'b0;
        rr_c     = '0;
        rr_idx   = '0;
        for (int i = 0; i < N; i++) begin
            rr_idx = {1'b0, rr_ptr_q} + (SW+1)'(i);
            if (rr_idx >= (SW+1)'(N)) rr_idx = rr_idx - (SW+1)'(N);
            if (!rr_found && in_valid[rr_idx[SW-1:0]]) begin
                rr_found = 1'b1;
                rr_c     = rr_idx[SW-1:0];
            end
        end
    end

    // Candidate choice and handshake; the slot is free when empty or being drained.
    always_comb begin
        s_ok     = {1'b0, s} < (SW+1)'(N);
        free     = !y_valid_q || out_ready;
        c        = mode ? rr_c : s;
        cand     = mode ? rr_found : s_ok;
        accept   = free && cand && in_valid[c];
        in_ready = accept ? (N'(1) << c) : '0;
    end

    // Next state: a new beat replaces the old one, otherwise a drain empties the slot.
    always_comb begin
        y_d       = accept ? ch[c] : y_q;
        y_sel_d   = accept ? c : y_sel_q;
        y_valid_d = accept || (y_valid_q && !out_ready);
        rr_ptr_d  = (accept && mode) ? ((c == SW'(N-1)) ? '0 : c + SW'(1)) : rr_ptr_q;
        sel_err_d = sel_err_q || (!mode && !s_ok && free);
    end

    // State registers, cleared asynchronously so an in-flight beat is dropped at once.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            y_q       <= '0;
            y_valid_q <= 1'b0;
            y_sel_q   <= '0;
            rr_ptr_q  <= '0;
            sel_err_q <= 1'b0;
        end else begin
            y_q       <= y_d;
            y_valid_q <= y_valid_d;
            y_sel_q   <= y_sel_d;
            rr_ptr_q  <= rr_ptr_d;
            sel_err_q <= sel_err_d;
        end
    end

    assign y       = y_q;
    assign y_valid = y_valid_q;
    assign y_sel   = y_sel_q;
`ifdef MUXN_SELERR_EN
    assign sel_err = sel_err_q;
`else
    logic unused_sel_err;
    assign unused_sel_err = sel_err_q;
`endif
endmodule
